// File: rtl/sync_buffer_mc_if.sv
// Sensor stream bundle: frame valid, line valid and multi-channel pixels.
//   fval     : frame valid
//   lval     : line valid
//   pix_data : CHANNEL_NUM pixels of DATA_WIDTH bits, channel 0 in the LSBs
// master drives the stream, slave receives it.
interface sync_buffer_mc_if #(
    parameter int DATA_WIDTH  = 10,
    parameter int CHANNEL_NUM = 4
);
    logic                              fval;
    logic                              lval;
    logic [DATA_WIDTH*CHANNEL_NUM-1:0] pix_data;

    modport master (output fval, lval, pix_data);
    modport slave  (input  fval, lval, pix_data);
endinterface

// File: rtl/sync_buffer_mc.sv
// Multi-channel sensor stream sync buffer with frame qualification.
// Registers the FVAL/LVAL/pixel stream, delays it by FVAL_MIN_WIDTH stages
// and releases a frame only when acquisition and stream enable were both high
// at its first sample and its FVAL lasted at least FVAL_MIN_WIDTH enabled
// cycles. Rejected frames are counted; the pixel format is shadowed at the
// output frame start.
// Ports:
//   clk_pix         : pixel clock
//   reset_n         : asynchronous active-low reset
//   i_clk_en        : cycle qualifier, every register holds when low
//   i_acq, i_se     : acquisition / stream enable
//   s_in            : sensor stream input (slave)
//   iv_pixel_format : live pixel-format register
//   m_out           : qualified stream output (master), registered
//   ov_pixel_format : pixel format shadowed at the output frame start
//   ov_drop_cnt     : saturating count of rejected frames
module sync_buffer_mc #(
    parameter int DATA_WIDTH     = 10,
    parameter int CHANNEL_NUM    = 4,
    parameter int FVAL_MIN_WIDTH = 3,
    parameter int PIX_FMT_WD     = 32,
    parameter int CNT_WD         = 16
) (
    input  logic                  clk_pix,
    input  logic                  reset_n,
    input  logic                  i_clk_en,
    input  logic                  i_acq,
    input  logic                  i_se,
    sync_buffer_mc_if.slave       s_in,
    input  logic [PIX_FMT_WD-1:0] iv_pixel_format,
    sync_buffer_mc_if.master      m_out,
    output logic [PIX_FMT_WD-1:0] ov_pixel_format,
    output logic [CNT_WD-1:0]     ov_drop_cnt
);
    localparam int N     = FVAL_MIN_WIDTH;
    localparam int PIX_W = DATA_WIDTH * CHANNEL_NUM;
    localparam int CQ_W  = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, QUAL, PASS, DROP} state_t;

    function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] v);
        return (&v) ? v : v + CNT_WD'(1);
    endfunction

    logic             fval_p0, lval_p0, en_p0, armed_p0;
    logic [PIX_W-1:0] data_p0;
    logic             fval_dl [1:N];
    logic             lval_dl [1:N];
    logic [PIX_W-1:0] data_dl [1:N];
    logic             o_fval, o_lval;
    logic [PIX_W-1:0] o_data;

    state_t          state, state_nxt;
    logic [CQ_W-1:0] cnt, cnt_nxt;
    logic            out_en, set_out_en, drop_inc, rise;

    // ---- stage s0: input capture ----
    // The enable is captured with the sample so it refers to the frame's first
    // sample. armed_p0 records that fval has been seen low since reset, so a
    // frame already running at reset release is never qualified.
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            fval_p0  <= 1'b0;
            lval_p0  <= 1'b0;
            data_p0  <= '0;
            en_p0    <= 1'b0;
            armed_p0 <= 1'b0;
        end else if (i_clk_en) begin
            fval_p0  <= s_in.fval;
            lval_p0  <= s_in.lval;
            data_p0  <= s_in.pix_data;
            en_p0    <= i_acq & i_se;
            armed_p0 <= armed_p0 | ~s_in.fval;
        end
    end

    // ---- stages d[1..N]: delay line covering the qualification window ----
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i <= N; i++) begin
                fval_dl[i] <= 1'b0;
                lval_dl[i] <= 1'b0;
                data_dl[i] <= '0;
            end
        end else if (i_clk_en) begin
            fval_dl[1] <= fval_p0;
            lval_dl[1] <= lval_p0;
            data_dl[1] <= data_p0;
            for (int i = 2; i <= N; i++) begin
                fval_dl[i] <= fval_dl[i-1];
                lval_dl[i] <= lval_dl[i-1];
                data_dl[i] <= data_dl[i-1];
            end
        end
    end

    // d[1].fval is s0.fval one enabled cycle earlier.
    assign rise = fval_p0 & ~fval_dl[1];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        set_out_en = 1'b0;
        drop_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    // out_en still high means the previous frame has not
                    // drained: the blanking gap was too short.
                    if (en_p0 && armed_p0 && !out_en) begin
                        state_nxt = QUAL;
                        cnt_nxt   = CQ_W'(1);
                    end else begin
                        state_nxt = DROP;
                        drop_inc  = 1'b1;
                    end
                end
            end
            QUAL: begin
                if (fval_p0) begin
                    if (cnt == CQ_W'(N - 1)) begin
                        state_nxt  = PASS;
                        set_out_en = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CQ_W'(1);
                    end
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    drop_inc  = 1'b1;
                end
            end
            PASS, DROP: begin
                if (!fval_p0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Decision is taken on the Nth high s0 sample, the same edge the frame
    // head enters d[N]. out_en is set only while low, and cleared once the
    // released frame has left d[N].
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            out_en          <= 1'b0;
            ov_pixel_format <= '0;
            ov_drop_cnt     <= '0;
        end else if (i_clk_en) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (set_out_en) begin
                out_en          <= 1'b1;
                ov_pixel_format <= iv_pixel_format;
            end else if (out_en && !fval_dl[N]) begin
                out_en <= 1'b0;
            end
            if (drop_inc)
                ov_drop_cnt <= sat_inc(ov_drop_cnt);
        end
    end

    // ---- output stage: gate d[N] with out_en ----
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            o_fval <= 1'b0;
            o_lval <= 1'b0;
            o_data <= '0;
        end else if (i_clk_en) begin
            o_fval <= fval_dl[N] & out_en;
            o_lval <= lval_dl[N] & fval_dl[N] & out_en;
            o_data <= (lval_dl[N] & fval_dl[N] & out_en) ? data_dl[N] : '0;
        end
    end

    assign m_out.fval     = o_fval;
    assign m_out.lval     = o_lval;
    assign m_out.pix_data = o_data;
endmodule

// File: doc/sync_buffer_mc.md
# sync_buffer_mc

Parametrised successor to the sensor stream sync buffer, for multi-channel sensor input. It registers the FVAL/LVAL/pixel stream and qualifies every frame before releasing it downstream. A frame is released only if acquisition and stream enable are both high at its start and its FVAL lasts at least `FVAL_MIN_WIDTH` qualified cycles. Frame format registers are shadowed at the output frame boundary. It sits between the sensor input capture and the pixel-format/data-path stage.

## Interface
- `DATA_WIDTH`, 10: bits per channel (8..16).
- `CHANNEL_NUM`, 4: pixel channels per clock (1, 2, 4, 8).
- `FVAL_MIN_WIDTH`, 3: minimum FVAL high length, in clk_en-qualified cycles (≥2). This is also the delay-line depth N.
- `PIX_FMT_WD`, 32: pixel-format register width.
- `CNT_WD`, 16: drop-counter width.

Ports:
- `clk_pix`  in  1  pixel clock; the only clock.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `i_clk_en`  in  1  cycle qualifier; all state advances only when high.
- `i_fval`  in  1  sensor frame valid.
- `i_lval`  in  1  sensor line valid.
- `iv_pix_data`  in  DATA_WIDTH*CHANNEL_NUM  sensor pixels; channel 0 in the LSBs.
- `i_acq`  in  1  acquisition enable.
- `i_se`  in  1  stream enable.
- `iv_pixel_format`  in  PIX_FMT_WD  pixel-format register, live value.
- `o_fval`  out  1  qualified frame valid.
- `o_lval`  out  1  qualified line valid.
- `ov_pix_data`  out  DATA_WIDTH*CHANNEL_NUM  qualified pixels.
- `ov_pixel_format`  out  PIX_FMT_WD  shadowed pixel format.
- `ov_drop_cnt`  out  CNT_WD  saturating count of rejected frames.

## Operation
- **Input stage s0:** registers {fval, lval, data} when `i_clk_en` is high.
- **Delay line d[1..N]:** shifts s0 forward when `i_clk_en` is high. d[N] feeds the output gate.
- **Input FSM states:** IDLE, QUAL, PASS, DROP. The FSM is evaluated on s0. Counter `cnt` is ceil(log2(N+1)) bits wide.
  - IDLE, s0.fval rise, (`i_acq`&`i_se`)=1 and out_en=0: go to QUAL, cnt=1.
  - IDLE, s0.fval rise, enable=0 or out_en=1: go to DROP. The out_en=1 case is a blanking gap shorter than the drain time. Drop count +1.
  - QUAL, fval high, cnt==N-1: go to PASS and set out_en=1.
  - QUAL, fval high otherwise: cnt+1.
  - QUAL, fval low: the frame is short. Go to IDLE, drop count +1. out_en stays 0.
  - PASS, fval low: go to IDLE.
  - DROP, fval low: go to IDLE.
- **Enables mid-frame:** changes to `i_acq`/`i_se` after the decision point have no effect. A passing frame always completes, and a dropped frame is never partially emitted.
- **out_en clear:** out_en clears on the cycle d[N].fval is seen falling while out_en=1.
- **Output gate:**
  - `o_fval` = d[N].fval & out_en.
  - `o_lval` = d[N].lval & `o_fval`.
  - `ov_pix_data` = d[N].data when `o_lval` is high, else 0.
  - All three are registered.
- **Shadow register:** `ov_pixel_format` loads `iv_pixel_format` on the cycle out_en goes 0→1, and holds for the rest of the frame.
- **Drop counter:** `ov_drop_cnt` saturates at all-ones. It is cleared only by reset.
- **Lval outside fval:** lval high while fval is low is masked at the output.

## Timing
- **Reset:** all outputs 0, state IDLE, cnt 0, out_en 0, delay line 0. Reset mid-frame aborts it immediately. After release, the first qualifying frame is the next s0.fval rise; a frame already high at release is dropped as a DROP frame.
- **Latency:** input pins to outputs is N+2 qualified cycles: s0, then N stages, then the output register. Latency is identical for fval, lval and data.
- **Decision timing:** the PASS decision is registered on the Nth high s0 sample, so the frame head reaches d[N] on the same cycle out_en is 1. No leading sample is lost.
- **Clock enable:** with `i_clk_en`=0 every register holds, including outputs, FSM and counters. Minimum-width counting is in enabled cycles only.
- **Minimum blanking:** a released frame needs ≥N+1 enabled fval-low cycles before the next frame can qualify. A shorter gap drops the next frame.
- **Exact-boundary frame:** a frame of exactly N cycles passes unchanged.

## Test plan
All scenarios use N=3, CHANNEL_NUM=4 and DATA_WIDTH=10.
- **Short frames:** fval high 2 cycles, acq=se=1 -> `o_fval` stays 0, `ov_drop_cnt` 0→1. fval high 1 cycle -> count 2.
- **Minimum frame:** fval high 3 cycles with lval high and data 0x3FF,0x155,0x2AA -> `o_fval` high 3 cycles starting 5 cycles after input rise. Data matches in order, and is 0 elsewhere.
- **Enable transitions:**
  - se=0 at rise, raised after 1 cycle -> whole 100-cycle frame suppressed, count +1. Next frame released.
  - se dropped mid-frame -> current frame emitted complete. Following frame dropped.
- **Short gap:** two valid 10-cycle frames 1 cycle apart -> first released, second dropped, count +1. With a 4-cycle gap both are released.
- **Shadowed format:** `iv_pixel_format` 0x0108000C→0x0110000D mid-frame -> `ov_pixel_format` changes only at the next output frame start.
- **Clock enable / reset:**
  - `i_clk_en` toggling 1,0 -> output identical to the enable=1 run, stretched 2×. A 3-enabled-cycle frame passes.
  - `reset_n` low mid-frame -> all outputs 0 within the same cycle, no partial frame after release.
